// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word requests over req/gnt + rvalid,
// buffers returned words and hands them to decode with valid/ready. Redirects flush and drop stale data.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [5:0]  out_op,
    output logic [5:0]  out_funct,
    output logic [15:0] out_imm
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [31:0] fetch_pc;
    cnt_t        fifo_count;
    cnt_t        outstanding;
    cnt_t        discard_cnt;
    ptr_t        fifo_wr_ptr;
    ptr_t        fifo_rd_ptr;
    ptr_t        tag_wr_ptr;
    ptr_t        tag_rd_ptr;

    logic [31:0] fifo_instr [FIFO_DEPTH];
    logic [31:0] fifo_pc    [FIFO_DEPTH];
    logic [31:0] tag_pc     [FIFO_DEPTH];

    logic credit_avail;
    logic accept;
    logic push;
    logic pop;
    logic unused_pc_bits;

    // Credits cover both buffered words and every in-flight request, stale ones included,
    // so a returning word always has a free FIFO slot.
    assign credit_avail = (fifo_count + outstanding) < cnt_t'(FIFO_DEPTH);
    assign imem_req     = rst_n && credit_avail && !redirect_valid;
    assign imem_addr    = fetch_pc;
    assign accept       = imem_req && imem_gnt;

    assign out_valid    = (fifo_count != '0);
    assign push         = imem_rvalid && (discard_cnt == '0) && !redirect_valid;
    assign pop          = out_valid && out_ready && !redirect_valid;

    assign unused_pc_bits = ^redirect_pc[1:0];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            fifo_count  <= '0;
            outstanding <= '0;
            discard_cnt <= '0;
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            tag_wr_ptr  <= '0;
            tag_rd_ptr  <= '0;
        end else begin
            outstanding <= outstanding + cnt_t'(accept) - cnt_t'(imem_rvalid);

            if (accept) begin
                fetch_pc   <= fetch_pc + 32'd4;
                tag_wr_ptr <= tag_wr_ptr + ptr_t'(1);
            end
            // Tags retire with every response, stale or not, so the tag queue stays aligned.
            if (imem_rvalid) begin
                tag_rd_ptr <= tag_rd_ptr + ptr_t'(1);
            end

            if (redirect_valid) begin
                fetch_pc    <= {redirect_pc[31:2], 2'b00};
                fifo_count  <= '0;
                fifo_wr_ptr <= '0;
                fifo_rd_ptr <= '0;
                discard_cnt <= outstanding - cnt_t'(imem_rvalid);
            end else begin
                if (imem_rvalid && (discard_cnt != '0)) begin
                    discard_cnt <= discard_cnt - cnt_t'(1);
                end
                if (push) begin
                    fifo_wr_ptr <= fifo_wr_ptr + ptr_t'(1);
                end
                if (pop) begin
                    fifo_rd_ptr <= fifo_rd_ptr + ptr_t'(1);
                end
                fifo_count <= fifo_count + cnt_t'(push) - cnt_t'(pop);
            end
        end
    end

    // NOTE: storage arrays are not reset; their contents only matter behind a valid count.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_pc[tag_wr_ptr] <= fetch_pc;
        end
        if (push) begin
            fifo_instr[fifo_wr_ptr] <= imem_rdata;
            fifo_pc[fifo_wr_ptr]    <= tag_pc[tag_rd_ptr];
        end
    end

    // NOTE: every output gets a default first so no latch is inferred on the empty path.
    always_comb begin
        out_instr = '0;
        out_pc    = '0;
        if (out_valid) begin
            out_instr = fifo_instr[fifo_rd_ptr];
            out_pc    = fifo_pc[fifo_rd_ptr];
        end
    end

    assign out_op    = out_instr[31:26];
    assign out_funct = out_instr[5:0];
    assign out_imm   = out_instr[15:0];

    a_rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n) imem_rvalid |-> (outstanding != '0));

    a_no_fifo_overflow: assert property (
        @(posedge clk) disable iff (!rst_n) (push && !pop) |-> (fifo_count < cnt_t'(FIFO_DEPTH)));

    a_discard_bounded: assert property (
        @(posedge clk) disable iff (!rst_n) discard_cnt <= outstanding);

endmodule
